updown_mod_counter: RTL and testbench
=====================================

# updown_mod_counter

Parametrised up/down modulo counter with synchronous clear, parallel load, clock-enable prescaler and rollover pulse. It is the general-purpose successor of the team's fixed 4-bit enable counter. It serves as the shared building block for the Ethernet datapath's timers, inter-frame-gap counters and byte counters. It is a single-clock-domain block that is driven directly by control logic.

## Interface
- `WIDTH`, default 4: counter width in bits; ≥ 1.
- `MODULUS`, default 16: count range 0..MODULUS-1; 2 ≤ MODULUS ≤ 2^WIDTH.
- `PRESCALE`, default 1: enabled cycles per count step; ≥ 1; 1 means every enabled cycle.
- `clock`  in  1  sole clock; rising-edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `enable`  in  1  count enable; low freezes counter and prescaler.
- `up_down`  in  1  1 = count up, 0 = count down.
- `clear`  in  1  synchronous clear.
- `load`  in  1  synchronous parallel load.
- `load_value`  in  WIDTH  value for load.
- `counter_out`  out  WIDTH  current count, registered.
- `terminal_count`  out  1  combinational from registered state. Asserted when counting up with count = MODULUS-1, or when counting down with count = 0.
- `wrap`  out  1  registered one-cycle pulse on rollover.

## Operation
- Reset (reset_n low, asynchronous): counter_out = 0, prescaler = 0, wrap = 0. Release is sampled on the next rising edge.
- Per-edge priority: clear > load > step > hold.
- `clear`: counter_out ← 0, prescaler ← 0, wrap ← 0. Independent of enable.
- `load`: counter_out ← load_value, prescaler ← 0, wrap ← 0. Independent of enable.
  - If load_value ≥ MODULUS, load MODULUS-1 (clamp).
- Prescaler: internal counter 0..PRESCALE-1, advanced only when enable = 1.
  - A step occurs on an enabled edge where prescaler = PRESCALE-1; the prescaler then returns to 0.
  - With PRESCALE = 1 the prescaler is optimised away and every enabled edge steps.
- Step up: count = MODULUS-1 → 0 with wrap = 1; otherwise count+1.
- Step down: count = 0 → MODULUS-1 with wrap = 1; otherwise count-1.
- wrap is 0 on every edge that does not produce a rollover.
- Changing up_down takes effect on the next step. It does not reset the prescaler.
- Arithmetic is WIDTH bits, unsigned. counter_out never leaves 0..MODULUS-1 unless the SATURATE build rules below say otherwise; they do not.

## Timing
- counter_out and wrap update on the rising edge at which clear, load or step is sampled, and are visible the same cycle after that edge. Latency from input to output: 1 clock.
- terminal_count follows counter_out and up_down combinationally. It has no added latency.
- Simultaneous clear + load: clear wins. Simultaneous load + enable: load wins and the prescaler restarts from 0.
- reset_n asserted mid-count forces all outputs to reset values immediately, without waiting for a clock edge.
- With enable held high and PRESCALE = P, counter_out changes every P cycles.

## Configuration
- `COUNTER_SATURATE_EN`
  - Defined: no rollover. A step up at MODULUS-1 holds MODULUS-1, and a step down at 0 holds 0. wrap is tied to 0. terminal_count is unchanged.
  - Undefined (default): modulo wrap and the wrap pulse behave as described in Operation.

## Test plan
- Reset then count: WIDTH = 4, MODULUS = 10, PRESCALE = 1, reset_n low then high, enable = 1, up_down = 1 → counter_out 0,1,…,9,0. wrap is high for exactly the cycle where counter_out shows 0 after 9. terminal_count is high while counter_out = 9.
- Down wrap: same parameters, load 2, up_down = 0 → counter_out 2,1,0,9. wrap pulses with 9. terminal_count is high at 0.
- Prescale: PRESCALE = 3, enable = 1 for 9 cycles from 0 → counter_out 0,0,0,1,1,1,2,2,2,3. Dropping enable for 2 cycles mid-group extends that group by 2 cycles.
- Priority and clamp: clear and load (load_value = 5) asserted together → counter_out 0. Load with load_value = 12 and MODULUS = 10 → counter_out 9.
- Async reset: assert reset_n low mid-cycle at count 6 → counter_out 0 before the next clock edge, and wrap = 0.
- `COUNTER_SATURATE_EN` defined: count up from 7 with MODULUS = 10 → 8,9,9,9 with wrap always 0. Count down from 1 → 0,0.

Source files
------------

// File: rtl/updown_mod_counter.sv
// Up/down modulo counter: synchronous clear, clamped parallel load, enable prescaler, rollover pulse.
// Build option COUNTER_SATURATE_EN: saturate at the range ends instead of wrapping (wrap stays 0).
module updown_mod_counter #(
    parameter int WIDTH    = 4,
    parameter int MODULUS  = 16,
    parameter int PRESCALE = 1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             up_down,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] counter_out,
    output logic             terminal_count,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] MAX_COUNT   = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH:0]   MODULUS_EXT = (WIDTH + 1)'(MODULUS);

    logic             step_tick;
    logic [WIDTH-1:0] count_reg;
    logic [WIDTH-1:0] count_next;
    logic             wrap_reg;
    logic             wrap_next;
    logic             at_top;
    logic             at_bottom;
    logic [WIDTH-1:0] load_clamped;

    generate
        if (PRESCALE > 1) begin : g_prescale
            localparam int PW = $clog2(PRESCALE);
            localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

            logic [PW-1:0] prescale_reg;

            // Clear and load restart the prescaler so a new count value always gets a full period.
            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    prescale_reg <= '0;
                end else if (clear || load) begin
                    prescale_reg <= '0;
                end else if (enable) begin
                    prescale_reg <= (prescale_reg == PRE_LAST) ? '0 : prescale_reg + PW'(1);
                end
            end

            assign step_tick = enable && (prescale_reg == PRE_LAST);
        end else begin : g_no_prescale
            assign step_tick = enable;
        end
    endgenerate

    assign at_top    = (count_reg == MAX_COUNT);
    assign at_bottom = (count_reg == '0);

    // Widened compare so MODULUS = 2^WIDTH never clamps.
    assign load_clamped = ({1'b0, load_value} >= MODULUS_EXT) ? MAX_COUNT : load_value;

    always_comb begin
        count_next = count_reg;
        wrap_next  = 1'b0;
        if (clear) begin
            count_next = '0;
        end else if (load) begin
            count_next = load_clamped;
        end else if (step_tick) begin
            if (up_down) begin
                if (at_top) begin
`ifdef COUNTER_SATURATE_EN
                    count_next = count_reg;
`else
                    count_next = '0;
                    wrap_next  = 1'b1;
`endif
                end else begin
                    count_next = count_reg + WIDTH'(1);
                end
            end else begin
                if (at_bottom) begin
`ifdef COUNTER_SATURATE_EN
                    count_next = count_reg;
`else
                    count_next = MAX_COUNT;
                    wrap_next  = 1'b1;
`endif
                end else begin
                    count_next = count_reg - WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_reg <= '0;
            wrap_reg  <= 1'b0;
        end else begin
            count_reg <= count_next;
            wrap_reg  <= wrap_next;
        end
    end

    assign counter_out    = count_reg;
    assign wrap           = wrap_reg;
    assign terminal_count = up_down ? at_top : at_bottom;

endmodule

// File: tb/tb_updown_mod_counter.sv
// Bench for updown_mod_counter: three parameter sets share stimulus, checked against an arithmetic model.
module tb_updown_mod_counter;

    logic       clock      = 1'b0;
    logic       reset_n    = 1'b0;
    logic       enable     = 1'b0;
    logic       up_down    = 1'b0;
    logic       clear      = 1'b0;
    logic       load       = 1'b0;
    logic [3:0] load_value = 4'd0;

    logic [3:0] c0, c1;
    logic [2:0] c2;
    logic       tc0, tc1, tc2, w0, w1, w2;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clock = ~clock;

    updown_mod_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(1)) dut0 (
        .clock(clock), .reset_n(reset_n), .enable(enable), .up_down(up_down),
        .clear(clear), .load(load), .load_value(load_value),
        .counter_out(c0), .terminal_count(tc0), .wrap(w0));

    updown_mod_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(3)) dut1 (
        .clock(clock), .reset_n(reset_n), .enable(enable), .up_down(up_down),
        .clear(clear), .load(load), .load_value(load_value),
        .counter_out(c1), .terminal_count(tc1), .wrap(w1));

    updown_mod_counter #(.WIDTH(3), .MODULUS(8), .PRESCALE(2)) dut2 (
        .clock(clock), .reset_n(reset_n), .enable(enable), .up_down(up_down),
        .clear(clear), .load(load), .load_value(load_value[2:0]),
        .counter_out(c2), .terminal_count(tc2), .wrap(w2));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: count range and prescale period per instance, plain modular arithmetic.
    int mods[3] = '{10, 10, 8};
    int pres[3] = '{1, 3, 2};
    int m_cnt[3] = '{0, 0, 0};
    int m_pre[3] = '{0, 0, 0};
    int m_wrap[3] = '{0, 0, 0};

    task automatic model_next(input int k, output int nc, output int np, output int nw);
        int m;
        int lv;
        m  = mods[k];
        lv = (k == 2) ? int'(load_value[2:0]) : int'(load_value);
        nc = m_cnt[k];
        np = m_pre[k];
        nw = 0;
        if (clear) begin
            nc = 0;
            np = 0;
        end else if (load) begin
            nc = (lv >= m) ? m - 1 : lv;
            np = 0;
        end else if (enable) begin
            np = m_pre[k] + 1;
            if (np == pres[k]) begin
                np = 0;
`ifdef COUNTER_SATURATE_EN
                if (up_down) nc = (m_cnt[k] + 1 > m - 1) ? m - 1 : m_cnt[k] + 1;
                else         nc = (m_cnt[k] == 0) ? 0 : m_cnt[k] - 1;
`else
                if (up_down) nc = (m_cnt[k] + 1) % m;
                else         nc = (m_cnt[k] + m - 1) % m;
                nw = up_down ? int'(nc == 0) : int'(m_cnt[k] == 0);
`endif
            end
        end
    endtask

    always @(posedge clock or negedge reset_n) begin
        int nc, np, nw;
        if (!reset_n) begin
            m_cnt  <= '{0, 0, 0};
            m_pre  <= '{0, 0, 0};
            m_wrap <= '{0, 0, 0};
        end else begin
            for (int k = 0; k < 3; k++) begin
                model_next(k, nc, np, nw);
                m_cnt[k]  <= nc;
                m_pre[k]  <= np;
                m_wrap[k] <= nw;
            end
        end
    end

    function automatic int exp_tc(input int k);
        return up_down ? int'(m_cnt[k] == mods[k] - 1) : int'(m_cnt[k] == 0);
    endfunction

    always @(posedge clock) begin
        #1;
        check("m0_cnt", 32'(c0), 32'(m_cnt[0]));
        check("m0_wrap", 32'(w0), 32'(m_wrap[0]));
        check("m0_tc", 32'(tc0), 32'(exp_tc(0)));
        check("m1_cnt", 32'(c1), 32'(m_cnt[1]));
        check("m1_wrap", 32'(w1), 32'(m_wrap[1]));
        check("m1_tc", 32'(tc1), 32'(exp_tc(1)));
        check("m2_cnt", 32'(c2), 32'(m_cnt[2]));
        check("m2_wrap", 32'(w2), 32'(m_wrap[2]));
        check("m2_tc", 32'(tc2), 32'(exp_tc(2)));
    end

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    initial begin
        tick();
        tick();
        check("rst_cnt0", 32'(c0), 0);
        check("rst_wrap0", 32'(w0), 0);
        check("rst_cnt1", 32'(c1), 0);

        reset_n = 1'b1;
        enable  = 1'b1;
        up_down = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            check("up_cnt", 32'(c0), 32'(i % 10));
            check("up_wrap", 32'(w0), 32'(i == 10));
            check("up_tc", 32'(tc0), 32'(i == 9));
            check("pre3_cnt", 32'(c1), 32'(i / 3));
        end

        // Two disabled cycles in the middle of a prescale group stretch it.
        enable = 1'b0;
        tick();
        tick();
        check("hold_cnt1", 32'(c1), 3);
        check("hold_cnt0", 32'(c0), 0);
        check("hold_wrap0", 32'(w0), 0);
        enable = 1'b1;
        tick();
        check("resume_cnt1", 32'(c1), 3);
        check("resume_cnt0", 32'(c0), 1);
        tick();
        check("resume_cnt1b", 32'(c1), 4);
        check("resume_cnt0b", 32'(c0), 2);

        load = 1'b1;
        load_value = 4'd2;
        tick();
        check("load2_cnt0", 32'(c0), 2);
        check("load2_cnt1", 32'(c1), 2);
        load = 1'b0;
        up_down = 1'b0;
        tick();
        check("dn_cnt0_1", 32'(c0), 1);
        tick();
        check("dn_cnt0_0", 32'(c0), 0);
        check("dn_tc0", 32'(tc0), 1);
        check("dn_cnt1_2", 32'(c1), 2);
        tick();
        check("dn_cnt0_9", 32'(c0), 9);
        check("dn_wrap0", 32'(w0), 1);
        check("dn_cnt1_1", 32'(c1), 1);

        // Asynchronous reset right after a wrap pulse.
        #3;
        reset_n = 1'b0;
        #1;
        check("arst_cnt0", 32'(c0), 0);
        check("arst_wrap0", 32'(w0), 0);
        check("arst_cnt1", 32'(c1), 0);
        tick();
        reset_n = 1'b1;

        clear = 1'b1;
        load = 1'b1;
        load_value = 4'd5;
        tick();
        check("clr_over_load0", 32'(c0), 0);
        check("clr_over_load1", 32'(c1), 0);
        clear = 1'b0;
        load_value = 4'd12;
        tick();
        check("clamp_cnt0", 32'(c0), 9);
        check("clamp_cnt1", 32'(c1), 9);
        check("clamp_cnt2", 32'(c2), 4);

        load_value = 4'd7;
        up_down = 1'b1;
        tick();
        check("sat_load7", 32'(c0), 7);
        load = 1'b0;
        tick();
        check("sat_up8", 32'(c0), 8);
        tick();
        check("sat_up9", 32'(c0), 9);
        tick();
`ifdef COUNTER_SATURATE_EN
        check("sat_top_cnt", 32'(c0), 9);
        check("sat_top_wrap", 32'(w0), 0);
`else
        check("sat_top_cnt", 32'(c0), 0);
        check("sat_top_wrap", 32'(w0), 1);
`endif
        load = 1'b1;
        load_value = 4'd1;
        up_down = 1'b0;
        tick();
        load = 1'b0;
        tick();
        check("sat_dn0", 32'(c0), 0);
        tick();
`ifdef COUNTER_SATURATE_EN
        check("sat_bot_cnt", 32'(c0), 0);
        check("sat_bot_wrap", 32'(w0), 0);
`else
        check("sat_bot_cnt", 32'(c0), 9);
        check("sat_bot_wrap", 32'(w0), 1);
`endif

        // Asynchronous reset mid-cycle while holding count 6.
        load = 1'b1;
        load_value = 4'd6;
        enable = 1'b0;
        tick();
        load = 1'b0;
        check("six_cnt0", 32'(c0), 6);
        #3;
        reset_n = 1'b0;
        #1;
        check("arst6_cnt0", 32'(c0), 0);
        check("arst6_wrap0", 32'(w0), 0);
        tick();
        reset_n = 1'b1;

        for (int i = 0; i < 3000; i++) begin
            clear  = ($urandom_range(0, 99) < 3);
            load   = ($urandom_range(0, 99) < 5);
            enable = ($urandom_range(0, 99) < 75);
            if ($urandom_range(0, 19) == 0) up_down = ~up_down;
            load_value = 4'($urandom);
            if ($urandom_range(0, 299) == 0) begin
                #3;
                reset_n = 1'b0;
                #1;
                check("rnd_arst_cnt0", 32'(c0), 0);
                check("rnd_arst_wrap0", 32'(w0), 0);
                tick();
                reset_n = 1'b1;
            end
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
